// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 32-bit ALU (add/sub/or, optional
// upper-load shift) behind a single-entry registered response slot.
// Optional feature macro: ALU_ARB_RR_EN. When it is defined, contention is
// resolved round-robin. When it is undefined, requester 0 always wins.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic        lu0,
    input  logic        lu1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;

    state_t      state;
    state_t      state_next;
    logic        accept_en;
    logic        any_gnt;
    logic [2:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_lu;
    logic [31:0] raw;
    logic [31:0] result;

`ifdef ALU_ARB_RR_EN
    logic        last_gnt;

    // Last-granted pointer; reset value 1 lets requester 0 win the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end
`endif

    // Response slot can take a new result when empty or being drained this cycle.
    always_comb begin
        accept_en = 1'b0;
        if (!reset) begin
            accept_en = (state == EMPTY) || rsp_ready;
        end
    end

    // Grant selection: single requester always wins, contention per build option.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (accept_en) begin
`ifdef ALU_ARB_RR_EN
            gnt0 = req0 && (!req1 || last_gnt);
            gnt1 = req1 && (!req0 || !last_gnt);
`else
            gnt0 = req0;
            gnt1 = req1 && !req0;
`endif
        end
        any_gnt = gnt0 || gnt1;
    end

    // Operand mux feeding the shared ALU from the granted requester.
    always_comb begin
        sel_op = op0;
        sel_a  = a0;
        sel_b  = b0;
        sel_lu = lu0;
        if (gnt1) begin
            sel_op = op1;
            sel_a  = a1;
            sel_b  = b1;
            sel_lu = lu1;
        end
    end

    // Shared ALU: modulo-2^32 add/sub, bitwise or, reserved codes give zero.
    always_comb begin
        raw = '0;
        unique case (sel_op)
            OP_ADD:  raw = sel_a + sel_b;
            OP_SUB:  raw = sel_a - sel_b;
            OP_OR:   raw = sel_a | sel_b;
            default: raw = '0;
        endcase
        result = sel_lu ? {raw[15:0], 16'h0000} : raw;
    end

    // Next-state logic for the single response slot.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (any_gnt) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !any_gnt) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Response register: loaded on any grant, otherwise held stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (any_gnt) begin
            rsp_id     <= gnt1;
            rsp_result <= result;
            rsp_zero   <= (result == 32'h0000_0000);
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a
// transaction-level reference model. Follows ALU_ARB_RR_EN like the design.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, a1, b0, b1;
    logic        lu0, lu1;
    logic        gnt0, gnt1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    int errors = 0;
    int checks = 0;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Reference model state
    bit          m_valid;
    bit          m_id;
    logic [31:0] m_result;
    bit          m_zero;
    int          m_last;
    bit          e_g0, e_g1;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .a0         (a0),
        .a1         (a1),
        .b0         (b0),
        .b1         (b1),
        .lu0        (lu0),
        .lu1        (lu1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    always #5 clk = ~clk;

    // Arithmetic on wide integers, reduced modulo 2^32.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic lu);
        longint unsigned m = 64'h1_0000_0000;
        longint unsigned r;
        longint unsigned ua = a;
        longint unsigned ub = b;
        case (op)
            3'd0:    r = (ua + ub) % m;
            3'd1:    r = (ua + m - ub) % m;
            3'd2:    r = ua | ub;
            default: r = 0;
        endcase
        if (lu) r = (r * 65536) % m;
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational grants mid-cycle, then registered outputs after the edge.
    task automatic cycle();
        bit accept;
        logic [31:0] r;
        @(negedge clk);
        accept = !reset && (!m_valid || rsp_ready);
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (accept) begin
            if (req0 && req1) begin
                if (RR && m_last == 0) e_g1 = 1'b1;
                else e_g0 = 1'b1;
            end else if (req0) begin
                e_g0 = 1'b1;
            end else if (req1) begin
                e_g1 = 1'b1;
            end
        end
        check("gnt0", {31'b0, gnt0}, {31'b0, e_g0});
        check("gnt1", {31'b0, gnt1}, {31'b0, e_g1});
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid  = 1'b0;
            m_id     = 1'b0;
            m_result = '0;
            m_zero   = 1'b0;
            m_last   = 1;
        end else if (e_g0 || e_g1) begin
            r = e_g1 ? ref_alu(op1, a1, b1, lu1) : ref_alu(op0, a0, b0, lu0);
            m_valid  = 1'b1;
            m_id     = e_g1;
            m_result = r;
            m_zero   = (r == 0);
            m_last   = e_g1 ? 1 : 0;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        check("rsp_valid",  {31'b0, rsp_valid}, {31'b0, m_valid});
        check("rsp_id",     {31'b0, rsp_id},    {31'b0, m_id});
        check("rsp_result", rsp_result,         m_result);
        check("rsp_zero",   {31'b0, rsp_zero},  {31'b0, m_zero});
    endtask

    initial begin
        m_valid = 0; m_id = 0; m_result = '0; m_zero = 0; m_last = 1;
        reset = 1'b1; req0 = 0; req1 = 0; op0 = '0; op1 = '0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; lu0 = 0; lu1 = 0; rsp_ready = 0;

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Single request: 5 + 7
        req0 = 1; op0 = 3'b000; a0 = 32'd5; b0 = 32'd7; rsp_ready = 1;
        cycle();
        check("single_result", rsp_result, 32'd12);
        req0 = 0;
        cycle();

        // Wrap and zero via requester 1
        req1 = 1; op1 = 3'b001; a1 = 32'd3; b1 = 32'd3;
        cycle();
        check("sub_zero_flag", {31'b0, rsp_zero}, 32'd1);
        a1 = 32'd0; b1 = 32'd1;
        cycle();
        check("sub_wrap", rsp_result, 32'hFFFF_FFFF);

        // Upper load and reserved op
        op1 = 3'b010; a1 = 32'd0; b1 = 32'h0001_ABCD; lu1 = 1;
        cycle();
        check("upper_load", rsp_result, 32'hABCD_0000);
        op1 = 3'b111;
        cycle();
        check("reserved_zero", {31'b0, rsp_zero}, 32'd1);
        lu1 = 0; req1 = 0;
        cycle();

        // Contention with both requesters held
        req0 = 1; req1 = 1; op0 = 3'b000; op1 = 3'b010;
        a0 = 32'h10; b0 = 32'h1; a1 = 32'hF0; b1 = 32'h0F;
        repeat (4) cycle();

        // Backpressure: pending response, req1 waits while rsp_ready=0
        req1 = 0; rsp_ready = 1;
        cycle();
        req0 = 0; req1 = 1; op1 = 3'b000; a1 = 32'd100; b1 = 32'd23; rsp_ready = 0;
        repeat (3) cycle();
        rsp_ready = 1;
        cycle();
        check("backpressure_result", rsp_result, 32'd123);
        req1 = 0;
        cycle();

        // Reset mid-operation, then contention must favour requester 0
        req0 = 1; op0 = 3'b000; a0 = 32'd1; b0 = 32'd1;
        cycle();
        reset = 1; req0 = 0;
        cycle();
        check("reset_drop_valid", {31'b0, rsp_valid}, 32'd0);
        reset = 0; req0 = 1; req1 = 1;
        cycle();
        check("post_reset_id", {31'b0, rsp_id}, 32'd0);
        req0 = 0; req1 = 0;
        cycle();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            req0      = $urandom_range(0, 1);
            req1      = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            op0       = 3'($urandom_range(0, 7));
            op1       = 3'($urandom_range(0, 7));
            a0        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b0        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            a1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            lu0       = $urandom_range(0, 1);
            lu1       = $urandom_range(0, 1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have ports req0/req1, input, 1 bit each: requester i holds an operation for the shared ALU.
REQ-004 The block SHALL have ports op0/op1, input, 3 bits each: operation code; 000 add, 001 sub, 010 or, all other codes reserved.
REQ-005 The block SHALL have ports a0/a1 and b0/b1, input, 32 bits each: operands A and B.
REQ-006 The block SHALL have ports lu0/lu1, input, 1 bit each: upper-load, which shifts the raw result left 16.
REQ-007 The block SHALL have ports gnt0/gnt1, output, 1 bit each: combinational acceptance of requester i in the current cycle.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: the response register holds a result.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the response this cycle.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: the index of the requester that owns the response.
REQ-011 The block SHALL have port rsp_result, output, 32 bits: the registered result.
REQ-012 The block SHALL have port rsp_zero, output, 1 bit: asserted when rsp_result equals 0.

Function
REQ-013 The block SHALL use a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-014 Accept-enable SHALL be asserted when the state is EMPTY, or when the state is FULL and rsp_ready=1.
REQ-015 When accept-enable is 0, the block SHALL hold gnt0 and gnt1 at 0.
REQ-016 At most one of gnt0 and gnt1 SHALL be asserted in any cycle.
REQ-017 With accept-enable asserted and only one requester active, that requester SHALL be granted.
REQ-018 With both requesters active, the block SHALL grant the requester that is not the last-granted one, per the round-robin rule in REQ-033.
REQ-019 When gnt_i=1, the block SHALL compute from that requester's op, a, b and lu, using the rules in REQ-021 to REQ-023.
REQ-020 On the clock edge after gnt_i=1, the block SHALL load rsp_result, rsp_zero and rsp_id=i, and set rsp_valid=1, giving 1-cycle latency.
REQ-021 Arithmetic SHALL be modulo 2^32: add gives a+b and sub gives a-b, with carry and borrow discarded; or gives a|b.
REQ-022 A reserved op code SHALL produce a raw result of 32'h0000_0000.
REQ-023 With lu=1, the block SHALL set the result to raw<<16, with the low 16 bits at 0 and the upper raw bits discarded; rsp_zero SHALL be computed on this shifted value.
REQ-024 A transition FULL to EMPTY SHALL occur when rsp_ready=1 and there is no grant.
REQ-025 When the state is FULL, rsp_ready=1 and a grant occurs in the same cycle, the state SHALL stay FULL and the response register SHALL be overwritten with the new result.
REQ-026 A transition EMPTY to FULL SHALL occur on any grant.
REQ-027 The block SHALL ignore rsp_ready while the state is EMPTY.
REQ-028 While the state is FULL and rsp_ready=0, rsp_result, rsp_zero and rsp_id SHALL stay stable.
REQ-029 A requester SHALL hold req and its operands stable until gnt; the block does not capture operands before granting.

Reset
REQ-030 While reset=1, the block SHALL drive rsp_valid=0, rsp_id=0, rsp_result=0 and rsp_zero=0.
REQ-031 While reset=1, the block SHALL drive gnt0=0 and gnt1=0.
REQ-032 While reset=1, the FSM SHALL be held in EMPTY.
REQ-033 While reset=1, the last-granted pointer SHALL be set to 1, so that requester 0 wins the first contention.
REQ-034 A reset asserted while the state is FULL SHALL drop the pending response, and the requester SHALL NOT be re-granted for it.

Configuration
REQ-035 The block SHALL support the macro ALU_ARB_RR_EN.
REQ-036 With ALU_ARB_RR_EN defined, contention SHALL be resolved by round-robin as in REQ-018.
REQ-037 With ALU_ARB_RR_EN undefined, requester 0 SHALL always win contention, and the last-granted pointer SHALL be absent.
REQ-038 All other behaviour SHALL be identical with and without ALU_ARB_RR_EN.

Verification
REQ-039 Single request: req0=1, op0=000, a0=5, b0=7, rsp_ready=1 -> gnt0=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-040 Wrap and zero: req1 with op=001, a=3, b=3 -> rsp_result=0, rsp_zero=1; then op=001, a=0, b=1 -> rsp_result=32'hFFFF_FFFF.
REQ-041 Upper load: op=010, a=0, b=32'h0001_ABCD, lu=1 -> rsp_result=32'hABCD_0000; reserved op=111 with lu=1 -> rsp_result=0, rsp_zero=1.
REQ-042 Contention with ALU_ARB_RR_EN, both requesters held active, rsp_ready=1 -> grants alternate 0,1,0,1 on consecutive cycles; without the macro -> gnt0 on every cycle and gnt1 never.
REQ-043 Backpressure: response pending, rsp_ready=0 for 3 cycles with req1=1 -> gnt1=0 and outputs stable; when rsp_ready=1 -> gnt1=1 in the same cycle and the new result appears on the next cycle.
REQ-044 Reset mid-operation: reset=1 on the cycle after a grant -> rsp_valid=0 and the pointer equals 1; after release, with both requesting, requester 0 is granted first.
